// File: rtl/ex_div.sv
// ex_div: iterative radix-2 restoring divider for DIV/DIVU in the EX stage
//   clk, rst            clock, synchronous active-high reset
//   start_i             division request, held until ready_o
//   signed_div_i        1 = DIV (two's complement), 0 = DIVU
//   opdata1_i/2_i       dividend / divisor
//   annul_i             abort the current operation
//   result_o            {remainder, quotient}, registered
//   ready_o             result valid, registered
//   stallreq_o          start_i & ~ready_o
//   Optional macro DIV_EARLY_OUT_EN: finish in 2 edges when |dividend| < |divisor|
module ex_div #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stallreq_o
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic [2*WIDTH:0] sr;
    logic [WIDTH-1:0] dvs, abs_a, abs_b, quo, rem;
    logic [WIDTH:0] diff;
    logic neg_q, neg_r, early;
    assign abs_a = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign abs_b = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
`ifdef DIV_EARLY_OUT_EN
    assign early = abs_a < abs_b;
`else
    assign early = 1'b0;
`endif
    // Borrow out of the widened subtraction marks a failed trial.
    assign diff = {1'b0, sr[2*WIDTH-1:WIDTH]} - {1'b0, dvs};
    assign quo = sr[WIDTH-1:0];
    assign rem = sr[2*WIDTH:WIDTH+1];
    assign stallreq_o = start_i & ~ready_o;
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FREE;
            cnt      <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state <= BYZERO;
                        end else begin
                            state <= ON;
                            dvs   <= abs_b;
                            neg_q <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                            neg_r <= signed_div_i & opdata1_i[WIDTH-1];
                            // Early out preloads the dividend as the remainder and skips straight to finalize.
                            sr    <= early ? {abs_a, {WIDTH{1'b0}}, 1'b0} : {{WIDTH{1'b0}}, abs_a, 1'b0};
                            cnt   <= early ? CW'(WIDTH) : '0;
                        end
                    end else begin
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end
                end
                BYZERO: begin
                    if (annul_i) begin
                        state <= FREE;
                    end else begin
                        state    <= END;
                        result_o <= '0;
                        ready_o  <= 1'b1;
                    end
                end
                ON: begin
                    if (annul_i) begin
                        state   <= FREE;
                        ready_o <= 1'b0;
                    end else if (cnt == CW'(WIDTH)) begin
                        state    <= END;
                        result_o <= {neg_r ? -rem : rem, neg_q ? -quo : quo};
                        ready_o  <= 1'b1;
                    end else begin
                        sr  <= diff[WIDTH] ? {sr[2*WIDTH-1:0], 1'b0} : {diff[WIDTH-1:0], sr[WIDTH-1:0], 1'b1};
                        cnt <= cnt + 1'b1;
                    end
                end
                END: begin
                    if (annul_i || !start_i) begin
                        state    <= FREE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/ex_div.md
Name: ex_div

Overview:
- Iterative radix-2 restoring divider in the EX stage; serves DIV/DIVU.
- Consumes the ID/EX outputs (aluop decoded to start/signed, reg1/reg2 as operands).
- Returns a 64-bit {remainder, quotient} for HI/LO writeback.
- Drives the EX stall request back into the pipeline stall controller, which holds stall[5:0] until the result is ready.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH bits; iteration count equals WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  division request; held high by EX until ready_o is seen.
- signed_div_i  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- opdata1_i  in  WIDTH  dividend (ex_reg1).
- opdata2_i  in  WIDTH  divisor (ex_reg2).
- annul_i  in  1  abort the current operation (flush or exception).
- result_o  out  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}; registered.
- ready_o  out  1  result valid; registered.
- stallreq_o  out  1  combinational: start_i & ~ready_o.

Behaviour:
- Reset, rst high at a clk edge:
  - state FREE, cnt 0, result_o 0, ready_o 0.
  - Reset mid-operation discards all progress; no partial result is ever exposed.
- States: FREE, BYZERO, ON, END.
- FREE:
  - start_i=1 & annul_i=0 & opdata2_i==0 -> BYZERO.
  - start_i=1 & annul_i=0, divisor nonzero -> ON. On this edge:
    - Latch operand magnitudes; negate negative operands when signed_div_i=1.
    - Latch sign flags.
    - Load the dividend shift register {WIDTH'b0, |dividend|, 1'b0}; cnt <= 0.
  - Otherwise: ready_o 0, result_o 0.
- BYZERO: next edge -> END with result_o 0, ready_o 1. Latency 2 edges from start.
- ON, annul_i=0, each edge:
  - Trial-subtract |divisor| from the upper WIDTH+1 bits.
  - If non-negative: replace the upper bits and shift in 1; else shift in 0. cnt++.
  - After WIDTH iterations (cnt==WIDTH) -> END, taking one extra edge to finalize.
- Finalize:
  - If signed and dividend sign XOR divisor sign: quotient is negated.
  - If signed and dividend negative: remainder is negated.
  - Load result_o, ready_o 1.
  - Total latency: ready_o rises WIDTH+2 edges after the start edge (34 for WIDTH=32).
- ON with annul_i=1: -> FREE at that edge, ready_o 0, result_o unchanged-irrelevant. annul_i in FREE blocks acceptance.
- END:
  - ready_o and result_o hold while start_i=1.
  - start_i=0 -> FREE, ready_o 0, result_o 0.
  - annul_i=1 -> FREE.
- Operand changes while in ON/END are ignored; only the values latched at acceptance are used.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. No trap.
- Back-to-back operations: a new start is accepted only from FREE, i.e. at least one idle cycle after END.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined:
  - In FREE, if the divisor is nonzero and |dividend| < |divisor|, go directly to END on the next edge.
  - Quotient 0; remainder equals the original signed dividend.
  - ready_o after 2 edges, same as BYZERO.
  - All other cases unchanged.
- Undefined: every nonzero divisor takes the full WIDTH+2 edges.

Test Plan:
- DIVU 100/7, start held:
  - ready_o rises exactly 34 edges after acceptance; result_o = {32'd2, 32'd14}.
  - stallreq_o high until ready_o, then low.
- DIV -7/2 (0xFFFFFFF9 / 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
- DIVU 5/0 -> ready_o after 2 edges, result_o 0; drop start -> FREE, ready_o 0 next edge.
- Annul mid-operation:
  - Start 1000/3, assert annul_i at iteration 10 -> FREE, ready_o never asserts.
  - New 9/4 accepted -> {1, 2} at +34.
  - Repeat with rst mid-operation: same outcome.
- DIVU 5/9:
  - With DIV_EARLY_OUT_EN -> {5, 0} after 2 edges.
  - Without the macro -> same value after 34 edges.
